// File: rtl/wb_grf.sv
// wb_grf: writeback data select, register file with W->D bypass, commit trace and counter.
module wb_grf #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int PC_LINK_OFF = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] W_PC,
    input  logic [DATA_W-1:0] W_ALURes,
    input  logic [DATA_W-1:0] W_MulDiv_Out,
    input  logic [DATA_W-1:0] W_DM_RD,
    input  logic              W_Reg_WE,
    input  logic [ADDR_W-1:0] W_Reg_WA,
    input  logic [2:0]        W_Reg_WD_sel,
    input  logic [ADDR_W-1:0] D_RA1,
    input  logic [ADDR_W-1:0] D_RA2,
    output logic [DATA_W-1:0] D_RD1,
    output logic [DATA_W-1:0] D_RD2,
    output logic [DATA_W-1:0] W_WD,
    output logic              trace_valid,
    output logic [DATA_W-1:0] trace_pc,
    output logic [ADDR_W-1:0] trace_wa,
    output logic [DATA_W-1:0] trace_wd,
    output logic [31:0]       commit_cnt
);
    localparam int N = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [N];
    logic [DATA_W-1:0] regs_d [N];
    logic              trace_valid_q, trace_valid_d;
    logic [DATA_W-1:0] trace_pc_q, trace_pc_d;
    logic [ADDR_W-1:0] trace_wa_q, trace_wa_d;
    logic [DATA_W-1:0] trace_wd_q, trace_wd_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              commit;

    always_comb begin
        W_WD = W_Reg_WD_sel == 3'd0 ? W_ALURes :
               W_Reg_WD_sel == 3'd1 ? W_DM_RD :
               W_Reg_WD_sel == 3'd2 ? W_PC + DATA_W'(PC_LINK_OFF) :
               W_Reg_WD_sel == 3'd3 ? W_MulDiv_Out : '0;
    end

    // $0 is never written, so a write to it is not a commit at all
    assign commit = W_Reg_WE && (W_Reg_WA != '0);

    assign D_RD1 = D_RA1 == '0 ? '0 : (commit && W_Reg_WA == D_RA1) ? W_WD : regs_q[D_RA1];
    assign D_RD2 = D_RA2 == '0 ? '0 : (commit && W_Reg_WA == D_RA2) ? W_WD : regs_q[D_RA2];

    always_comb begin
        regs_d = regs_q;
        if (commit) regs_d[W_Reg_WA] = W_WD;
        trace_valid_d = commit;
        trace_pc_d    = commit ? W_PC : trace_pc_q;
        trace_wa_d    = commit ? W_Reg_WA : trace_wa_q;
        trace_wd_d    = commit ? W_WD : trace_wd_q;
        cnt_d         = cnt_q + 32'(commit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) regs_q[i] <= '0;
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_wa_q    <= '0;
            trace_wd_q    <= '0;
            cnt_q         <= '0;
        end else begin
            regs_q        <= regs_d;
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            trace_wa_q    <= trace_wa_d;
            trace_wd_q    <= trace_wd_d;
            cnt_q         <= cnt_d;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_pc    = trace_pc_q;
    assign trace_wa    = trace_wa_q;
    assign trace_wd    = trace_wd_q;
    assign commit_cnt  = cnt_q;
endmodule

// File: tb/tb_wb_grf.sv
// tb_wb_grf: directed vectors against hand-computed expectations for wb_grf.
module tb_wb_grf;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, alu, md, dm;
    logic        we;
    logic [4:0]  wa, ra1, ra2;
    logic [2:0]  sel;
    logic [31:0] rd1, rd2, wd, t_pc, t_wd, cnt;
    logic [4:0]  t_wa;
    logic        t_valid;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    wb_grf dut (
        .clk(clk), .rst(rst), .W_PC(pc), .W_ALURes(alu), .W_MulDiv_Out(md), .W_DM_RD(dm),
        .W_Reg_WE(we), .W_Reg_WA(wa), .W_Reg_WD_sel(sel), .D_RA1(ra1), .D_RA2(ra2),
        .D_RD1(rd1), .D_RD2(rd2), .W_WD(wd), .trace_valid(t_valid), .trace_pc(t_pc),
        .trace_wa(t_wa), .trace_wd(t_wd), .commit_cnt(cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [2:0] s,
                         input logic [31:0] p, input logic [31:0] al,
                         input logic [31:0] d, input logic [31:0] m);
        @(negedge clk);
        we = w; wa = a; sel = s; pc = p; alu = al; dm = d; md = m;
    endtask

    initial begin
        rst = 1'b1; ra1 = '0; ra2 = '0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            chk($sformatf("rst_rd1[%0d]", i), rd1, 32'h0);
            chk($sformatf("rst_rd2[%0d]", 31 - i), rd2, 32'h0);
        end
        chk("rst_cnt", cnt, 32'h0);
        chk("rst_tvalid", 32'(t_valid), 32'h0);

        drive(1, 5, 0, 32'h100, 32'h1234, 0, 0);
        ra1 = 5; ra2 = 5; #1;
        chk("byp_rd1", rd1, 32'h1234);
        chk("byp_rd2", rd2, 32'h1234);
        chk("byp_wd", wd, 32'h1234);
        drive(0, 0, 0, 0, 0, 0, 0);
        ra1 = 5; #1;
        chk("grf5", rd1, 32'h1234);
        chk("tr_valid1", 32'(t_valid), 32'h1);
        chk("tr_wa1", 32'(t_wa), 32'h5);
        chk("tr_pc1", t_pc, 32'h100);
        chk("tr_wd1", t_wd, 32'h1234);
        chk("cnt1", cnt, 32'h1);

        drive(1, 31, 2, 32'h3000, 0, 0, 0); #1;
        chk("link_wd", wd, 32'h3008);
        drive(1, 30, 2, 32'hFFFF_FFFC, 0, 0, 0); #1;
        chk("link_wrap_wd", wd, 32'h4);
        drive(0, 0, 0, 0, 0, 0, 0);
        ra1 = 31; ra2 = 30; #1;
        chk("grf31", rd1, 32'h3008);
        chk("grf30", rd2, 32'h4);
        chk("cnt3", cnt, 32'h3);

        drive(1, 10, 0, 0, 32'h55, 0, 0);
        drive(1, 8, 1, 0, 32'h1, 32'hDEAD_BEEF, 32'h2);
        drive(1, 9, 3, 0, 32'h1, 32'h3, 32'h7);
        drive(1, 10, 5, 0, 32'hAAAA, 32'hBBBB, 32'hCCCC); #1;
        chk("sel5_wd", wd, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        ra1 = 8; ra2 = 9; #1;
        chk("grf8", rd1, 32'hDEAD_BEEF);
        chk("grf9", rd2, 32'h7);
        ra1 = 10; #1;
        chk("grf10", rd1, 32'h0);
        chk("tr_wa10", 32'(t_wa), 32'd10);
        chk("cnt7", cnt, 32'h7);

        drive(1, 0, 0, 32'h200, 32'hFFFF, 0, 0);
        ra1 = 0; #1;
        chk("r0_rd", rd1, 32'h0);
        chk("r0_wd", wd, 32'hFFFF);
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        chk("r0_tvalid", 32'(t_valid), 32'h0);
        chk("r0_cnt", cnt, 32'h7);
        chk("r0_trwa_hold", 32'(t_wa), 32'd10);
        chk("r0_rd_after", rd1, 32'h0);

        drive(1, 3, 0, 0, 32'h77, 0, 0);
        rst = 1'b1; ra1 = 3; #1;
        chk("rst_byp", rd1, 32'h77);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0; ra1 = 3; ra2 = 5; #1;
        chk("rst_grf3", rd1, 32'h0);
        chk("rst_grf5", rd2, 32'h0);
        chk("rst_cnt2", cnt, 32'h0);
        chk("rst_tvalid2", 32'(t_valid), 32'h0);
        chk("rst_trwa", 32'(t_wa), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
